hp1349a_bus_rx: RTL and testbench

- Parametrised successor to the HP1349A bus-interface-plus-FIFO front end.
- Receives words from the host over the LDAV/LRFD bus and synchronises the asynchronous strobe.
- Waits a programmable data-settle interval, then captures the word into an internal show-ahead FIFO.
- Presents the FIFO as a valid/ready stream to the display control block; adds watermark back-pressure, glitch rejection and status counters.

---
 rtl/hp1349a_bus_rx.sv | 180 ++++++++++++++++++
 tb/tb_hp1349a_bus_rx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp1349a_bus_rx.sv
// rtl/hp1349a_bus_rx.sv - HP1349A-style LDAV/LRFD bus receiver with show-ahead FIFO
//
// Host-side handshake receiver. An asynchronous active-low LDAV strobe from the
// host is synchronised. It must then stay low for SETTLE_CYCLES synchronised
// cycles before BUS_DATA is captured into an internal show-ahead FIFO. The FIFO
// is drained as a valid/ready stream.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   BUS_LDAV     host data-available strobe (active low, asynchronous)
//   BUS_LRFD     ready-for-data to host (active low, registered)
//   BUS_DATA     host data word, stable while LDAV is low
//   out_valid    FIFO head word valid
//   out_ready    consumer accepts head word
//   out_data     FIFO head word (zero when not valid)
//   fill         current FIFO occupancy
//   word_count   words captured since reset (saturating)
//   glitch_count LDAV pulses shorter than the settle interval (saturating)

module hp1349a_bus_rx #(
    parameter int DATA_W        = 15,
    parameter int DEPTH_LOG2    = 4,
    parameter int HIGH_WATER    = 12,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  BUS_LDAV,
    output logic                  BUS_LRFD,
    input  logic [DATA_W-1:0]     BUS_DATA,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [DEPTH_LOG2:0]   fill,
    output logic [CNT_W-1:0]      word_count,
    output logic [CNT_W-1:0]      glitch_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SC_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DEPTH_LOG2:0] HW_F        = (DEPTH_LOG2+1)'(HIGH_WATER);
    localparam logic [SC_W-1:0]     SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [SC_W-1:0]         settle_q, settle_d;
    logic                    lrfd_q, lrfd_d;
    logic [DEPTH_LOG2:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]     rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic                    out_valid_q, out_valid_d;
    logic [CNT_W-1:0]        word_count_q, word_count_d;
    logic [CNT_W-1:0]        glitch_count_q, glitch_count_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic ldav_s;
    logic push;
    logic pop;
    logic lrfd_idle;

    assign ldav_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], BUS_LDAV};

        // Writes happen only in CAPTURE, so push is known before the FSM case.
        push     = (state_q == CAPTURE);
        pop      = out_valid_q & out_ready;
        wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(push);
        rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(pop);
        fill_d   = wr_ptr_d - rd_ptr_d;
        out_valid_d = (fill_d != '0);

        // LRFD level for IDLE, computed from next-cycle fill so the flop
        // tracks occupancy without an extra cycle of lag.
        lrfd_idle = (fill_d >= HW_F);

        state_d        = state_q;
        settle_d       = settle_q;
        lrfd_d         = lrfd_q;
        word_count_d   = word_count_q;
        glitch_count_d = glitch_count_q;

        case (state_q)
            IDLE: begin
                if (!ldav_s && !lrfd_q) begin
                    // The entry cycle already counts as one settled cycle.
                    state_d  = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
                    settle_d = SC_W'(1);
                    lrfd_d   = 1'b0;
                end else begin
                    lrfd_d = lrfd_idle;
                end
            end
            SETTLE: begin
                lrfd_d = 1'b0;
                if (ldav_s) begin
                    state_d        = IDLE;
                    lrfd_d         = lrfd_idle;
                    glitch_count_d = (glitch_count_q == '1) ? glitch_count_q
                                                            : glitch_count_q + CNT_W'(1);
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q + SC_W'(1);
                end
            end
            CAPTURE: begin
                lrfd_d       = 1'b1;
                state_d      = RELEASE;
                word_count_d = (word_count_q == '1) ? word_count_q
                                                    : word_count_q + CNT_W'(1);
            end
            RELEASE: begin
                // One word per LDAV low pulse: wait for the strobe to return high.
                lrfd_d = 1'b1;
                if (ldav_s) begin
                    state_d = IDLE;
                    lrfd_d  = lrfd_idle;
                end
            end
            default: begin
                state_d = IDLE;
                lrfd_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sync_q         <= '1;
            settle_q       <= '0;
            lrfd_q         <= 1'b1;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            out_valid_q    <= 1'b0;
            word_count_q   <= '0;
            glitch_count_q <= '0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            settle_q       <= settle_d;
            lrfd_q         <= lrfd_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            out_valid_q    <= out_valid_d;
            word_count_q   <= word_count_d;
            glitch_count_q <= glitch_count_d;
        end
    end

    // Storage has no reset; push is derived from reset state so a reset
    // during a transfer can never commit a partial write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= BUS_DATA;
        end
    end

    assign BUS_LRFD     = lrfd_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_valid_q ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : '0;
    assign fill         = fill_q;
    assign word_count   = word_count_q;
    assign glitch_count = glitch_count_q;

endmodule

// File: tb/tb_hp1349a_bus_rx.sv
// tb/tb_hp1349a_bus_rx.sv - directed self-checking bench for hp1349a_bus_rx

module tb_hp1349a_bus_rx;

    localparam int DW = 15;
    localparam int DL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_ldav, a_ready, a_lrfd, a_valid;
    logic [DW-1:0] a_data, a_out;
    logic [DL:0]   a_fill;
    logic [15:0]   a_wc, a_gc;

    logic          b_ldav, b_ready, b_lrfd, b_valid;
    logic [DW-1:0] b_data, b_out;
    logic [DL:0]   b_fill;
    logic [15:0]   b_wc, b_gc;

    hp1349a_bus_rx u_dut (
        .clk(clk), .rst(rst), .BUS_LDAV(a_ldav), .BUS_LRFD(a_lrfd), .BUS_DATA(a_data),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_out), .fill(a_fill),
        .word_count(a_wc), .glitch_count(a_gc)
    );

    hp1349a_bus_rx #(.HIGH_WATER(16)) u_dut16 (
        .clk(clk), .rst(rst), .BUS_LDAV(b_ldav), .BUS_LRFD(b_lrfd), .BUS_DATA(b_data),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_out), .fill(b_fill),
        .word_count(b_wc), .glitch_count(b_gc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [DW-1:0] w);
        int k;
        a_data = w;
        a_ldav = 1'b0;
        k = 0;
        while (a_lrfd !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk("a_send_capture", 32'(k < 60), 1);
        a_ldav = 1'b1;
        tick(4);
    endtask

    task automatic send_b(input logic [DW-1:0] w);
        int k;
        b_data = w;
        b_ldav = 1'b0;
        exp_q.push_back(w);
        k = 0;
        while (b_lrfd !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk("b_send_capture", 32'(k < 60), 1);
        b_ldav = 1'b1;
        tick(4);
    endtask

    // Occupancy model for the wide-threshold instance: fill follows
    // captures (word_count steps) minus accepted pops, cycle by cycle.
    logic        mon_en = 1'b0;
    logic        mon_ok = 1'b0;
    logic [DL:0] pf;
    logic [15:0] pwc;
    logic        pv, pr;
    int          sim_cnt = 0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("a_fill_bound", 32'(a_fill <= 16), 1);
        end
        if (mon_en) begin
            if (mon_ok) begin
                chk("b_fill_model", 32'(b_fill),
                    32'(int'(pf) + int'(b_wc != pwc) - int'(pv & pr)));
                chk("b_fill_bound", 32'(b_fill <= 16), 1);
                if ((b_wc != pwc) && pv && pr) sim_cnt++;
            end
            pf     = b_fill;
            pwc    = b_wc;
            pv     = b_valid;
            pr     = b_ready;
            mon_ok = 1'b1;
        end else begin
            mon_ok = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int            rise, vc, k, got, hi;
        logic [DW-1:0] seen;

        rst = 1'b0;
        a_ldav = 1'b1; a_ready = 1'b1; a_data = '0;
        b_ldav = 1'b1; b_ready = 1'b0; b_data = '0;
        tick(3);

        // Reset values
        chk("rst_lrfd", 32'(a_lrfd), 1);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_data", 32'(a_out), 0);
        chk("rst_fill", 32'(a_fill), 0);
        chk("rst_wc", 32'(a_wc), 0);
        chk("rst_gc", 32'(a_gc), 0);

        rst = 1'b1;
        tick(2);
        chk("idle_lrfd_low", 32'(a_lrfd), 0);

        // Single word: 2 sync + 4 settle + 1 capture edges until LRFD rises
        a_data = 15'h1234;
        a_ldav = 1'b0;
        rise = 0; vc = 0; seen = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (a_lrfd && rise == 0) rise = i;
            if (a_valid) begin
                vc++;
                seen = a_out;
            end
        end
        chk("t1_lrfd_rise", 32'(rise), 7);
        chk("t1_valid_pulses", 32'(vc), 1);
        chk("t1_data", 32'(seen), 32'h1234);
        chk("t1_wc", 32'(a_wc), 1);
        a_ldav = 1'b1;
        k = 0;
        while (a_lrfd && k < 20) begin
            tick();
            k++;
        end
        // Synchroniser stages plus the registered FSM reaction
        chk("t1_lrfd_release", 32'(k), 3);

        // Glitch: 3-cycle pulse is rejected
        tick(3);
        a_data = 15'h0bad;
        a_ldav = 1'b0;
        hi = 0; vc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_lrfd) hi++;
            if (a_valid) vc++;
        end
        a_ldav = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_lrfd) hi++;
            if (a_valid) vc++;
        end
        chk("t2_gc", 32'(a_gc), 1);
        chk("t2_lrfd_high_cycles", 32'(hi), 0);
        chk("t2_no_valid", 32'(vc), 0);
        chk("t2_wc", 32'(a_wc), 1);

        // Back-pressure at the 12-word watermark
        a_ready = 1'b0;
        for (int i = 0; i < 12; i++) send_a(DW'(i));
        chk("t3_fill12", 32'(a_fill), 12);
        chk("t3_lrfd_held", 32'(a_lrfd), 1);
        a_data = 15'd12;
        a_ldav = 1'b0;
        tick(15);
        chk("t3_13th_blocked_fill", 32'(a_fill), 12);
        chk("t3_13th_blocked_wc", 32'(a_wc), 13);
        chk("t3_head0", 32'(a_out), 0);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        chk("t3_fill11", 32'(a_fill), 11);
        chk("t3_lrfd_reopen", 32'(a_lrfd), 0);
        k = 0;
        while (!a_lrfd && k < 30) begin
            tick();
            k++;
        end
        chk("t3_13th_wc", 32'(a_wc), 14);
        a_ldav = 1'b1;
        tick(4);
        chk("t3_fill_after13", 32'(a_fill), 12);
        a_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 12; c++) begin
            if (a_valid) begin
                chk("t3_order", 32'(a_out), 32'(got + 1));
                got++;
            end
            tick();
        end
        chk("t3_drain_count", 32'(got), 12);
        chk("t3_drained_fill", 32'(a_fill), 0);

        // Concurrency and pointer wrap on the HIGH_WATER=16 instance
        mon_en = 1'b1;
        send_b(15'h0a01);
        send_b(15'h0a02);
        chk("t4_pre_fill", 32'(b_fill), 2);
        b_data = 15'h0a03;
        b_ldav = 1'b0;
        exp_q.push_back(15'h0a03);
        tick(6);
        b_ready = 1'b1;
        chk("t4_head_before", 32'(b_out), 32'h0a01);
        tick();
        b_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("t4_pushpop_fill", 32'(b_fill), 2);
        chk("t4_pushpop_wc", 32'(b_wc), 3);
        chk("t4_pushpop_head", 32'(b_out), 32'h0a02);
        chk("t4_pushpop_lrfd", 32'(b_lrfd), 1);
        b_ldav = 1'b1;
        tick(4);

        fork
            begin
                for (int i = 0; i < 40; i++) send_b(DW'(15'h2000 + i * 7));
            end
            begin
                int g, cyc;
                g = 0; cyc = 0;
                while (b_fill < 8 && cyc < 2000) begin
                    tick();
                    cyc++;
                end
                while (g < 42 && cyc < 5000) begin
                    b_ready = ~b_ready;
                    if (b_valid && b_ready) begin
                        if (exp_q.size() == 0) chk("t4_underflow", 1, 0);
                        else chk("t4_stream_data", 32'(b_out), 32'(exp_q.pop_front()));
                        g++;
                    end
                    tick();
                    cyc++;
                end
                b_ready = 1'b0;
                chk("t4_stream_count", 32'(g), 42);
            end
        join
        tick(2);
        mon_en = 1'b0;
        chk("t4_final_fill", 32'(b_fill), 0);
        chk("t4_wc", 32'(b_wc), 43);
        chk("t4_gc", 32'(b_gc), 0);
        chk("t4_simul_seen", 32'(sim_cnt > 0), 1);

        // Held LDAV: exactly one capture
        a_ready = 1'b1;
        a_data = 15'h7abc;
        a_ldav = 1'b0;
        vc = 0; seen = '0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (a_valid) begin
                vc++;
                seen = a_out;
            end
        end
        chk("t5_wc", 32'(a_wc), 15);
        chk("t5_valid_pulses", 32'(vc), 1);
        chk("t5_data", 32'(seen), 32'h7abc);
        chk("t5_lrfd_held", 32'(a_lrfd), 1);
        a_ldav = 1'b1;
        tick(3);
        chk("t5_lrfd_release", 32'(a_lrfd), 0);

        // Reset two cycles into SETTLE
        a_ready = 1'b0;
        send_a(15'h0555);
        chk("t6_pre_fill", 32'(a_fill), 1);
        a_data = 15'h0666;
        a_ldav = 1'b0;
        tick(5);
        rst = 1'b0;
        #1;
        chk("t6_lrfd", 32'(a_lrfd), 1);
        chk("t6_valid", 32'(a_valid), 0);
        chk("t6_data", 32'(a_out), 0);
        chk("t6_fill", 32'(a_fill), 0);
        chk("t6_wc", 32'(a_wc), 0);
        chk("t6_gc", 32'(a_gc), 0);
        a_ldav = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(5);
        chk("t6_post_fill", 32'(a_fill), 0);
        chk("t6_post_wc", 32'(a_wc), 0);
        chk("t6_post_lrfd", 32'(a_lrfd), 0);
        chk("t6_post_valid", 32'(a_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
